// File: rtl/div16_core.sv
// Unsigned WIDTH-bit restoring divider: one quotient bit per clock, MSB first.
// Starts on a rising edge of init; divide-by-zero completes in a single clock.
module div16_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [WIDTH-1:0]   op_A,
  input  logic [WIDTH-1:0]   op_B,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic               init_q;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               ge;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;

  always_comb begin
    start   = init & ~init_q;
    // Remainder stays below the divisor, so the shift never loses a set MSB.
    rem_sh  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_sub = rem_sh - {1'b0, dvs_q};

    state_d  = state_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (op_B != '0) begin
            state_d = StCalc;
            dvd_d   = op_A;
            dvs_d   = op_B;
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = CntW'(WIDTH);
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d  = StDone;
            result_d = {op_A, {WIDTH{1'b1}}};
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
      StCalc: begin
        rem_d = ge ? rem_sub : rem_sh;
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d  = StDone;
          result_d = {rem_d[WIDTH-1:0], quo_d};
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      init_q   <= 1'b0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_div16_core.sv
// Scoreboard bench for div16_core: the driver queues expected responses with their
// start cycle, and a monitor checks done/busy/result cycle by cycle against them.
module tb_div16_core;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [15:0] op_A;
  logic [15:0] op_B;
  logic [31:0] result;
  logic        done;
  logic        busy;

  div16_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .op_A  (op_A),
    .op_B  (op_B),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e0;
    int          lat;
    logic [31:0] exp;
    logic [31:0] prev;
    bit          hold;
    bit          hdone;
    bit          hbusy;
    string       name;
  } item_t;

  item_t       sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_exp;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: op items are checked every cycle of their window, hold items once.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0) begin
        item_t it;
        int    k;
        it = sb[0];
        k  = cyc - it.e0;
        if (k < 0) break;
        if (it.hold) begin
          chk({it.name, "/done"}, 32'(done), 32'(it.hdone));
          chk({it.name, "/busy"}, 32'(busy), 32'(it.hbusy));
          chk({it.name, "/result"}, result, it.exp);
          void'(sb.pop_front());
        end else if (k < it.lat) begin
          chk({it.name, "/done_low"}, 32'(done), 32'd0);
          chk({it.name, "/busy_high"}, 32'(busy), 32'd1);
          chk({it.name, "/result_held"}, result, it.prev);
          break;
        end else begin
          chk({it.name, "/done"}, 32'(done), 32'd1);
          chk({it.name, "/busy"}, 32'(busy), 32'd0);
          chk({it.name, "/result"}, result, it.exp);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_op(input logic [15:0] b, input logic [31:0] exp, input string name);
    item_t it;
    it.e0    = cyc;
    it.lat   = (b == 16'd0) ? 0 : W;
    it.exp   = exp;
    it.prev  = cur_exp;
    it.hold  = 1'b0;
    it.hdone = 1'b0;
    it.hbusy = 1'b0;
    it.name  = name;
    sb.push_back(it);
    cur_exp = exp;
  endtask

  task automatic hold_chk(input logic [31:0] r, input bit d, input bit bsy, input string name);
    item_t it;
    it.e0    = cyc;
    it.lat   = 0;
    it.exp   = r;
    it.prev  = r;
    it.hold  = 1'b1;
    it.hdone = d;
    it.hbusy = bsy;
    it.name  = name;
    sb.push_back(it);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                          input string name, input bit track);
    @(negedge clk);
    op_A = a;
    op_B = b;
    init = 1'b1;
    @(posedge clk);
    #1;
    if (track) push_op(b, exp, name);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input string name);
    start_op(a, b, exp, name, 1'b1);
    @(negedge clk);
    init = 1'b0;
    repeat ((b == 16'd0) ? 0 : W) @(posedge clk);
  endtask

  logic [15:0] ta [10] = '{16'd100, 16'hFFFF, 16'd3, 16'hFFFF, 16'd5, 16'd0, 16'd0,
                           16'h8000, 16'hFFFF, 16'd1000};
  logic [15:0] tb_ [10] = '{16'd7, 16'd1, 16'd10, 16'hFFFF, 16'd0, 16'd5, 16'd0,
                            16'h8001, 16'h8000, 16'd3};
  logic [31:0] te [10] = '{32'h0002_000E, 32'h0000_FFFF, 32'h0003_0000, 32'h0000_0001,
                           32'h0005_FFFF, 32'h0000_0000, 32'h0000_FFFF, 32'h8000_0000,
                           32'h7FFF_0001, 32'h0001_014D};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] e;
    reset   = 1'b1;
    init    = 1'b0;
    op_A    = '0;
    op_B    = '0;
    cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    hold_chk(32'd0, 1'b0, 1'b0, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_op(ta[i], tb_[i], te[i], $sformatf("vec%0d", i));

    // Restart request, operand changes mid-calculation must not disturb the run.
    start_op(16'd1000, 16'd3, 32'h0001_014D, "midcalc", 1'b1);
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    init = 1'b1;
    op_A = 16'd5;
    op_B = 16'd0;
    @(negedge clk);
    init = 1'b0;
    op_A = 16'hFFFF;
    op_B = 16'd1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    op_A = 16'd7;
    op_B = 16'd9;
    @(posedge clk);
    #1;
    hold_chk(32'h0001_014D, 1'b1, 1'b0, "done_hold");

    // init held high: exactly one operation.
    start_op(16'd100, 16'd7, 32'h0002_000E, "held_init", 1'b1);
    repeat (20) @(posedge clk);
    #1;
    hold_chk(32'h0002_000E, 1'b1, 1'b0, "held_once");
    @(negedge clk);
    init = 1'b0;

    // Reset at cycle 8 of a calculation aborts it.
    start_op(16'd1000, 16'd3, 32'd0, "abort", 1'b0);
    @(negedge clk);
    init = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    hold_chk(32'd0, 1'b0, 1'b0, "abort");
    cur_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    hold_chk(32'd0, 1'b0, 1'b0, "idle_after_abort");

    // Reset beats a start at the same edge; init high at release starts at once.
    do_op(16'd9, 16'd4, 32'h0001_0002, "pre_rst");
    @(negedge clk);
    reset = 1'b1;
    init  = 1'b1;
    op_A  = 16'd100;
    op_B  = 16'd7;
    @(posedge clk);
    #1;
    hold_chk(32'd0, 1'b0, 1'b0, "rst_priority");
    cur_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_op(16'd7, 32'h0002_000E, "init_at_release");
    @(negedge clk);
    init = 1'b0;
    repeat (W) @(posedge clk);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      if (i % 10 == 0)     b = 16'd0;
      else if (i % 3 == 1) b = 16'($urandom_range(1, 15));
      else                 b = 16'($urandom);
      e = (b == 16'd0) ? {a, 16'hFFFF} : {a % b, a / b};
      do_op(a, b, e, $sformatf("rand%0d_%0d_%0d", i, a, b));
    end

    for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
